// File: rtl/mimc_pkg.sv
// Shared definitions for the MiMC cipher arbiter: default field width,
// job sequencer states and the requester id width helper.
package mimc_pkg;

    // BN254 scalar field element width
    localparam int N_BITS_DEFAULT = 254;

    // Job sequencer states
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // Width needed to index n requesters (never narrower than one bit)
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping. The pointer register is owned by the parent.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    int              sum;
    logic [ID_W-1:0] cand;

    // Walk the requesters in priority order starting at the pointer
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = 0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = int'(ptr) + k;
            if (sum >= N_REQ) begin
                sum = sum - N_REQ;
            end
            cand = ID_W'(sum);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/mimc_cipher_arbiter.sv
// Shares a single MiMC cipher core among N_REQ requesters. Jobs are granted
// round-robin, one in flight at a time, and a watchdog turns a cipher that
// never completes into an error response.
module mimc_cipher_arbiter
    import mimc_pkg::*;
#(
    parameter int  N_BITS  = N_BITS_DEFAULT,
    parameter int  N_REQ   = 4,
    parameter int  TIMEOUT = 4096,
    localparam int ID_W    = id_width(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*N_BITS-1:0] req_in,
    input  logic [N_REQ*N_BITS-1:0] req_key,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [N_BITS-1:0]       resp_out,
    output logic                    resp_err,
    output logic                    cip_en,
    output logic [N_BITS-1:0]       cip_in,
    output logic [N_BITS-1:0]       cip_key,
    input  logic [N_BITS-1:0]       cip_out,
    input  logic                    cip_done
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [WD_W-1:0]   wd;
    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_any;
    logic [N_BITS-1:0] sel_in;
    logic [N_BITS-1:0] sel_key;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // Accept is only offered while idle and never while reset is asserted
    assign req_ready = (state == IDLE && !rst) ? grant : '0;

    // One-hot operand mux for the granted requester
    always_comb begin
        sel_in  = '0;
        sel_key = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_in  = req_in[i*N_BITS +: N_BITS];
                sel_key = req_key[i*N_BITS +: N_BITS];
            end
        end
    end

    // Job sequencer: accept, start the cipher, wait under watchdog, hold result
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            wd         <= '0;
            cip_en     <= 1'b0;
            cip_in     <= '0;
            cip_key    <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_out   <= '0;
            resp_err   <= 1'b0;
        end else begin
            cip_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        cip_in  <= sel_in;
                        cip_key <= sel_key;
                        resp_id <= grant_idx;
                        rr_ptr  <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        cip_en  <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd    <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cip_done) begin
                        resp_out   <= cip_out;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        resp_out   <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (wd != '1) begin
                        wd <= wd + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
